// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// Memory stage of a Y86-64 style five-stage pipeline. It owns the 1024-byte
// data memory, performs the load or store selected by the instruction in the
// M register, reports the effective status of the instruction, and holds the
// W pipeline register that feeds write-back.
//
// Ports
//   clk       in   1   pipeline clock, all state updates on the rising edge
//   rst       in   1   asynchronous, active-high reset of the W register
//   M_stat    in   2   status carried in the M register
//   M_icode   in   4   instruction code carried in the M register
//   M_Cnd     in   1   condition flag (already resolved upstream, not used here)
//   M_valE    in  64   ALU result, used as address for most memory icodes
//   M_valA    in  64   store data, and address for popq/ret
//   M_dstE    in   4   destination register for valE
//   M_dstM    in   4   destination register for valM
//   W_stall   in   1   hold the W register
//   W_bubble  in   1   load a nop into the W register (stall wins)
//   m_valM    out 64   combinational read data (0 when not reading)
//   m_stat    out  2   combinational effective status
//   W_stat    out  2   registered status
//   W_icode   out  4   registered instruction code
//   W_valE    out 64   registered valE
//   W_valM    out 64   registered valM
//   W_dstE    out  4   registered dstE
//   W_dstM    out  4   registered dstM
//
// Configuration
//   DMEM_BOUNDS_CHECK_EN  When defined, any access whose 64-bit address is
//                         above 1016 is an address error: m_stat becomes ADR
//                         and the store is suppressed. When undefined, every
//                         byte index wraps modulo 1024 and this block never
//                         raises ADR.
//
// Status codes: 0 AOK, 1 HLT, 2 ADR, 3 INS.
// -----------------------------------------------------------------------------
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat,
  output logic [1:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_ADR = 2'd2;

  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam int MEM_BYTES = 1024;

  // ---------------------------------------------------------------------------
  // Data memory. Deliberately has no reset: contents survive rst.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:MEM_BYTES-1];

  // M_Cnd has already steered dstE in execute; it is carried in the M
  // register only for completeness. Tie it into a sink so it is consumed.
  logic unused;
  assign unused = M_Cnd;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic       mem_read;
  logic       mem_write;
  logic       addr_from_vala;
  logic       addr_err;
  logic [9:0] base_index;

  always_comb begin
    mem_read       = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ) ||
                     (M_icode == I_RET);
    mem_write      = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) ||
                     (M_icode == I_CALL);
    // popq and ret read through the stack pointer value carried in valA.
    addr_from_vala = (M_icode == I_POPQ) || (M_icode == I_RET);
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  // Full 64-bit address is needed for the range compare; the last legal
  // start address is 1016 so that all 8 bytes fit below 1024.
  logic [63:0] mem_addr;

  always_comb begin
    mem_addr   = addr_from_vala ? M_valA : M_valE;
    addr_err   = (mem_read || mem_write) && (mem_addr > 64'd1016);
    base_index = mem_addr[9:0];
  end
`else
  // Only the low 10 bits matter: every byte index wraps modulo 1024.
  always_comb begin
    base_index = addr_from_vala ? M_valA[9:0] : M_valE[9:0];
    addr_err   = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Combinational little-endian read. The 10-bit add wraps on its own, which
  // gives the modulo-1024 behaviour; with bounds checking on, an in-range
  // address never reaches the wrap.
  // ---------------------------------------------------------------------------
  logic [63:0] read_word;

  always_comb begin
    read_word = '0;
    for (int i = 0; i < 8; i++) begin
      read_word[i*8 +: 8] = mem[base_index + 10'(i)];
    end
  end

  always_comb begin
    m_valM = '0;
    if (mem_read && !addr_err) begin
      m_valM = read_word;
    end
  end

  always_comb begin
    m_stat = M_stat;
    if (addr_err) begin
      m_stat = STAT_ADR;
    end
  end

  // ---------------------------------------------------------------------------
  // Store. Commits all 8 bytes on one edge. Only a healthy instruction with a
  // legal address may write, and nothing is written while rst is high. The
  // W register controls have no influence on the store.
  // ---------------------------------------------------------------------------
  logic write_en;

  always_comb begin
    write_en = mem_write && (M_stat == STAT_AOK) && !addr_err && !rst;
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base_index + 10'(i)] <= M_valA[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // W pipeline register. Reset and bubble both produce the canonical nop.
  // Stall has priority over bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
    end else if (!W_stall) begin
      if (W_bubble) begin
        W_stat  <= STAT_AOK;
        W_icode <= I_NOP;
        W_valE  <= '0;
        W_valM  <= '0;
        W_dstE  <= REG_NONE;
        W_dstM  <= REG_NONE;
      end else begin
        W_stat  <= m_stat;
        W_icode <= M_icode;
        W_valE  <= M_valE;
        W_valM  <= m_valM;
        W_dstE  <= M_dstE;
        W_dstM  <= M_dstM;
      end
    end
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have inputs from the M pipeline register: M_stat 2, M_icode 4, M_Cnd 1, M_valE 64, M_valA 64, M_dstE 4, M_dstM 4.
REQ-004 SHALL have port: W_stall  input  1  hold the W register.
REQ-005 SHALL have port: W_bubble  input  1  load a nop into the W register.
REQ-006 SHALL have combinational outputs for forwarding and control: m_valM 64 (read data) and m_stat 2 (effective status).
REQ-007 SHALL have registered outputs: W_stat 2, W_icode 4, W_valE 64, W_valM 64, W_dstE 4, W_dstM 4.
REQ-008 Status encoding SHALL be 0 AOK, 1 HLT, 2 ADR, 3 INS.

Function
REQ-009 Data memory SHALL be 1024 bytes, byte-addressed, with little-endian 64-bit accesses.
REQ-010 Reads SHALL occur for icode 5 (mrmovq) and icode 11/9 (popq/ret).
REQ-011 Writes SHALL occur for icode 4 (rmmovq), icode 10 (pushq) and icode 8 (call).
REQ-012 Address selection SHALL be: M_valE for icodes 4, 5, 10, 8; M_valA for icodes 11, 9.
REQ-013 Write data SHALL always be M_valA.
REQ-014 m_valM SHALL be the combinational 8-byte read at the selected address when reading, else 0.
REQ-015 A memory write SHALL commit on the rising clk edge only when all of the following hold: write icode, M_stat==AOK, no address error.
REQ-016 A write SHALL update all 8 bytes in the same edge.
REQ-017 A write SHALL be unaffected by W_stall and W_bubble.
REQ-018 m_stat SHALL be ADR when a read or write icode has an address error, else M_stat.
REQ-019 W register load: on a rising edge with W_stall=0 and W_bubble=0, W_* SHALL take m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM.
REQ-020 W_bubble=1 with W_stall=0 SHALL load a nop: W_stat=0, W_icode=1, W_valE=0, W_valM=0, W_dstE=15, W_dstM=15.
REQ-021 W_stall=1 SHALL hold all W_* values, and stall SHALL take priority over a simultaneous W_bubble.
REQ-022 Read-after-write to the same address in consecutive cycles SHALL return the new data: the write commits at the edge and the read is combinational afterwards.
REQ-023 A same-cycle read and write cannot occur, since each icode is either read or write.
REQ-024 Non-memory icodes SHALL pass M_stat through to m_stat and perform no memory access.

Reset
REQ-025 rst=1 SHALL asynchronously force the W register to the nop values of REQ-020, independent of clk.
REQ-026 While rst=1, no memory write SHALL commit.
REQ-027 Memory contents SHALL NOT be cleared by reset; they are preserved across reset.
REQ-028 Deasserting rst mid-operation SHALL resume normal loading at the next rising edge.

Configuration
REQ-029 Macro DMEM_BOUNDS_CHECK_EN SHALL select address handling.
REQ-030 With DMEM_BOUNDS_CHECK_EN defined, an address error SHALL be flagged when address > 1016 (unsigned 64-bit compare), setting m_stat=ADR and suppressing the write.
REQ-031 Without DMEM_BOUNDS_CHECK_EN, the address SHALL wrap: each byte index is (addr+i) mod 1024, no ADR is ever generated by this block, and m_stat=M_stat.

Verification
REQ-032 rmmovq M_icode=4, M_valE=0x100, M_valA=0x1122334455667788, then mrmovq M_icode=5, M_valE=0x100 next cycle -> m_valM=0x1122334455667788; one edge later W_valM=0x1122334455667788, byte 0x100=0x88.
REQ-033 popq M_icode=11, M_valA=0x100, M_dstM=3 -> read uses M_valA; W_dstM=3, W_valM equals stored word.
REQ-034 With DMEM_BOUNDS_CHECK_EN, pushq M_valE=1020 -> m_stat=2, no write occurs (bytes 1016..1023 unchanged), W_stat=2. Without the macro: write wraps to bytes 1020..1023, 0..3, and W_stat=0.
REQ-035 Load W, then assert W_stall=1 and W_bubble=1 together with new inputs -> W_* unchanged; release W_stall with W_bubble=1 -> W_icode=1, W_dstE=15, W_dstM=15.
REQ-036 rmmovq with M_stat=1 (HLT) -> no memory write, W_stat=1.
REQ-037 Assert rst between clk edges -> W_* go to nop values immediately; memory contents written earlier still read back unchanged after rst drops.
